// File: rtl/tinuc_dmem_resp.sv
// tinuc_dmem_resp: data-memory slave for the TinuC core; word RAM plus an MMIO window (GPIO, cycle counter, compare timer).
// Latency: reads are combinational from daddr (same cycle); writes and register updates take effect at the next CLK edge.
// Backpressure: none; every access completes in one cycle, so the core never stalls on this port.
//
// Ports:
//   CLK, RESET        clock and asynchronous active-high reset
//   daddr, ddata_w    byte address and write data from the core MEM stage
//   d_rw              1 = write this cycle, 0 = read
//   ddata_r           read data, combinational from daddr
//   gpio_out          GPIO output register
//   timer_irq         registered timer-pending flag
//
// Build option: define DMEM_MMIO_TIMER_EN to include CYCLE, TIMER_CMP and TIMER_CTRL.
// Without it those addresses read 0, ignore writes, and timer_irq is tied 0.
module tinuc_dmem_resp #(
  parameter int                ADDR_W    = 10,
  parameter int                DATA_W    = 32,
  parameter logic [ADDR_W-1:0] MMIO_BASE = 10'h3E0,
  parameter int                GPIO_W    = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] ddata_w,
  input  logic              d_rw,
  output logic [DATA_W-1:0] ddata_r,
  output logic [GPIO_W-1:0] gpio_out,
  output logic              timer_irq
);

  localparam int                RAM_DEPTH = int'(MMIO_BASE) / 4;
  localparam logic [ADDR_W-3:0] MMIO_WORD = MMIO_BASE[ADDR_W-1:2];

  localparam logic [ADDR_W-3:0] OFF_GPIO  = (ADDR_W-2)'(0);
`ifdef DMEM_MMIO_TIMER_EN
  localparam logic [ADDR_W-3:0] OFF_CYCLE = (ADDR_W-2)'(1);
  localparam logic [ADDR_W-3:0] OFF_CMP   = (ADDR_W-2)'(2);
  localparam logic [ADDR_W-3:0] OFF_CTRL  = (ADDR_W-2)'(3);
`endif

  // Byte lanes are not supported, so the two low address bits are dropped.
  logic              unused_addr_lo;
  logic [ADDR_W-3:0] word_idx;
  logic              is_ram;
  logic [ADDR_W-3:0] mmio_off;

  assign unused_addr_lo = ^daddr[1:0];
  assign word_idx       = daddr[ADDR_W-1:2];
  assign is_ram         = (daddr < MMIO_BASE);
  assign mmio_off       = word_idx - MMIO_WORD;

  logic wr_gpio;
  assign wr_gpio = d_rw && !is_ram && (mmio_off == OFF_GPIO);

  // ---------------------------------------------------------------------------
  // Word RAM: not reset. A write at an edge where RESET is high is dropped.
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] mem [RAM_DEPTH];

  always_ff @(posedge CLK) begin
    if (d_rw && is_ram && !RESET) begin
      mem[word_idx] <= ddata_w;
    end
  end

  // ---------------------------------------------------------------------------
  // GPIO register
  // ---------------------------------------------------------------------------
  logic [GPIO_W-1:0] gpio_q;
  logic [GPIO_W-1:0] gpio_d;

  assign gpio_d = wr_gpio ? ddata_w[GPIO_W-1:0] : gpio_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      gpio_q <= '0;
    end else begin
      gpio_q <= gpio_d;
    end
  end

  assign gpio_out = gpio_q;

`ifdef DMEM_MMIO_TIMER_EN
  // ---------------------------------------------------------------------------
  // Cycle counter and compare timer
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] cycle_q, cycle_d;
  logic [DATA_W-1:0] cmp_q, cmp_d;
  logic              en_q, en_d;
  logic              pend_q, pend_d;
  logic              wr_cycle, wr_cmp, wr_ctrl;
  logic              match;

  assign wr_cycle = d_rw && !is_ram && (mmio_off == OFF_CYCLE);
  assign wr_cmp   = d_rw && !is_ram && (mmio_off == OFF_CMP);
  assign wr_ctrl  = d_rw && !is_ram && (mmio_off == OFF_CTRL);

  // Compare against the counter value before this edge's update or load.
  assign match    = en_q && (cycle_q == cmp_q);

  // A software load of CYCLE overrides the free-running increment.
  assign cycle_d  = wr_cycle ? ddata_w : (cycle_q + DATA_W'(1));
  assign cmp_d    = wr_cmp ? ddata_w : cmp_q;
  assign en_d     = wr_ctrl ? ddata_w[0] : en_q;
  // A new match beats a simultaneous write-1-to-clear so no event is lost.
  assign pend_d   = match | (pend_q & ~(wr_ctrl & ddata_w[1]));

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cycle_q <= '0;
      cmp_q   <= '0;
      en_q    <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      cycle_q <= cycle_d;
      cmp_q   <= cmp_d;
      en_q    <= en_d;
      pend_q  <= pend_d;
    end
  end

  assign timer_irq = pend_q;
`else
  assign timer_irq = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Combinational read mux: RAM below MMIO_BASE, registers above, else 0
  // ---------------------------------------------------------------------------
  always_comb begin
    ddata_r = '0;
    if (is_ram) begin
      ddata_r = mem[word_idx];
    end else begin
      case (mmio_off)
        OFF_GPIO:  ddata_r = {{(DATA_W-GPIO_W){1'b0}}, gpio_q};
`ifdef DMEM_MMIO_TIMER_EN
        OFF_CYCLE: ddata_r = cycle_q;
        OFF_CMP:   ddata_r = cmp_q;
        OFF_CTRL:  ddata_r = {{(DATA_W-2){1'b0}}, pend_q, en_q};
`endif
        default:   ddata_r = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_tinuc_dmem_resp.sv
module tb_tinuc_dmem_resp;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [9:0]  daddr = '0;
  logic [31:0] ddata_w = '0;
  logic        d_rw = 1'b0;
  logic [31:0] ddata_r;
  logic [7:0]  gpio_out;
  logic        timer_irq;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [31:0] ram_m [248];
  bit          ram_vld [248];
  logic [7:0]  gpio_m = '0;
  logic [31:0] cycle_m = '0;
  logic [31:0] cmp_m = '0;
  bit          en_m = 1'b0;
  bit          pend_m = 1'b0;

  tinuc_dmem_resp dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .daddr     (daddr),
    .ddata_w   (ddata_w),
    .d_rw      (d_rw),
    .ddata_r   (ddata_r),
    .gpio_out  (gpio_out),
    .timer_irq (timer_irq)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [9:0] a);
    logic [31:0] r;
    r = 32'h0;
    if (a < 10'h3E0) begin
      r = ram_m[int'(a >> 2)];
    end else begin
      case (a & 10'h3FC)
        10'h3E0: r = {24'h0, gpio_m};
`ifdef DMEM_MMIO_TIMER_EN
        10'h3E4: r = cycle_m;
        10'h3E8: r = cmp_m;
        10'h3EC: r = {30'h0, pend_m, en_m};
`endif
        default: r = 32'h0;
      endcase
    end
    return r;
  endfunction

  function automatic void model_reset();
    gpio_m  = '0;
    cycle_m = '0;
    cmp_m   = '0;
    en_m    = 1'b0;
    pend_m  = 1'b0;
  endfunction

  // One clock cycle: drive, check outputs against the model before the edge,
  // clock, then advance the model by the rules of the register map.
  task automatic step(input logic [9:0] a, input logic [31:0] wd, input logic rw);
    int w;
    bit mt;
    daddr   = a;
    ddata_w = wd;
    d_rw    = rw;
    #2;
    w = int'(a >> 2);
    if (a >= 10'h3E0) chk("rd_mmio", ddata_r, exp_rd(a));
    else if (ram_vld[w]) chk("rd_ram", ddata_r, exp_rd(a));
    chk("gpio", {24'h0, gpio_out}, {24'h0, gpio_m});
    chk("irq", {31'h0, timer_irq}, {31'h0, pend_m});
    @(posedge CLK);
    if (rw && a < 10'h3E0) begin
      ram_m[w]   = wd;
      ram_vld[w] = 1'b1;
    end
    if (rw && w == 248) gpio_m = wd[7:0];
`ifdef DMEM_MMIO_TIMER_EN
    mt = en_m && (cycle_m == cmp_m);
    if (rw && w == 251 && wd[1]) pend_m = 1'b0;
    if (mt) pend_m = 1'b1;
    if (rw && w == 251) en_m = wd[0];
    if (rw && w == 250) cmp_m = wd;
    cycle_m = (rw && w == 249) ? wd : cycle_m + 32'd1;
`else
    mt = 1'b0;
    if (mt) pend_m = 1'b1;
`endif
    #1;
  endtask

  // Combinational read peek within the current cycle (no clock edge).
  task automatic look(input logic [9:0] a);
    daddr = a;
    d_rw  = 1'b0;
    #1;
  endtask

  initial begin
    logic [9:0]  ra;
    logic [31:0] rd;
    logic        rw;

    // Reset
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b0;
    model_reset();

    look(10'h3E0);
    chk("rst_gpio_rd", ddata_r, 32'h0);
    chk("rst_gpio_out", {24'h0, gpio_out}, 32'h0);
    chk("rst_irq", {31'h0, timer_irq}, 32'h0);
`ifdef DMEM_MMIO_TIMER_EN
    look(10'h3E4);
    chk("rst_cycle", ddata_r, 32'h0);
`endif

    // Fill RAM so every later read has a defined expectation
    for (int i = 0; i < 248; i++) step(10'(i * 4), $urandom, 1'b1);

    // RAM write then read with low address bits set
    step(10'h010, 32'hDEADBEEF, 1'b1);
    look(10'h013);
    chk("ram_lowbits", ddata_r, 32'hDEADBEEF);

    // Read-during-write at the same address
    step(10'h020, 32'h1, 1'b1);
    daddr = 10'h020; ddata_w = 32'h2; d_rw = 1'b1; #1;
    chk("rdw_old", ddata_r, 32'h1);
    step(10'h020, 32'h2, 1'b1);
    look(10'h020);
    chk("rdw_new", ddata_r, 32'h2);

    // GPIO and reserved space
    step(10'h3E0, 32'h1A5, 1'b1);
    look(10'h3E0);
    chk("gpio_out", {24'h0, gpio_out}, 32'hA5);
    chk("gpio_rd", ddata_r, 32'h000000A5);
    step(10'h3F4, 32'hFFFF, 1'b1);
    look(10'h3F4);
    chk("resv_rd", ddata_r, 32'h0);

`ifdef DMEM_MMIO_TIMER_EN
    // Counter wrap and compare
    step(10'h3E4, 32'hFFFFFFFE, 1'b1);
    step(10'h3E8, 32'h1, 1'b1);
    step(10'h3EC, 32'h1, 1'b1);
    look(10'h3E4);
    chk("cyc_wrap", ddata_r, 32'h0);
    step(10'h000, 32'h0, 1'b0);
    look(10'h3E4);
    chk("cyc_one", ddata_r, 32'h1);
    chk("irq_pre", {31'h0, timer_irq}, 32'h0);
    step(10'h000, 32'h0, 1'b0);
    chk("irq_set", {31'h0, timer_irq}, 32'h1);
    step(10'h3EC, 32'h3, 1'b1);
    chk("irq_w1c", {31'h0, timer_irq}, 32'h0);
    // Match and clear on the same edge: the set wins
    step(10'h3E8, cycle_m + 32'd2, 1'b1);
    step(10'h000, 32'h0, 1'b0);
    step(10'h3EC, 32'h3, 1'b1);
    chk("set_wins", {31'h0, timer_irq}, 32'h1);
    step(10'h3EC, 32'h0, 1'b1);
    chk("en_clr_keeps", {31'h0, timer_irq}, 32'h1);
    step(10'h3EC, 32'h2, 1'b1);
    chk("irq_clr2", {31'h0, timer_irq}, 32'h0);
`else
    step(10'h3E4, 32'h55, 1'b1);
    look(10'h3E4);
    chk("notimer_rd", ddata_r, 32'h0);
    for (int i = 0; i < 100; i++) step(10'h3EC, 32'hFFFFFFFF, 1'($urandom_range(0, 1)));
    chk("notimer_irq", {31'h0, timer_irq}, 32'h0);
`endif

    // Randomized traffic over RAM and the whole MMIO window
    for (int i = 0; i < 500; i++) begin
      ra = ($urandom_range(0, 3) == 0) ? 10'(10'h3E0 + $urandom_range(0, 31))
                                       : 10'($urandom_range(0, 1023));
      rd = $urandom;
      rw = 1'($urandom_range(0, 1));
      if (rw && (ra >> 2) == 10'd250 && $urandom_range(0, 1) == 1)
        rd = cycle_m + 32'($urandom_range(1, 6));
      if (rw && (ra >> 2) == 10'd249 && $urandom_range(0, 1) == 1)
        rd = cmp_m - 32'($urandom_range(1, 4));
      step(ra, rd, rw);
    end

    // Async reset with GPIO and pending timer set
    step(10'h3E0, 32'hFF, 1'b1);
`ifdef DMEM_MMIO_TIMER_EN
    step(10'h3EC, 32'h1, 1'b1);
    step(10'h3E8, cycle_m + 32'd1, 1'b1);
    step(10'h000, 32'h0, 1'b0);
    chk("pre_rst_irq", {31'h0, timer_irq}, 32'h1);
`endif
    chk("pre_rst_gpio", {24'h0, gpio_out}, 32'hFF);
    daddr = 10'h040; ddata_w = ~ram_m[16]; d_rw = 1'b1;
    #2 RESET = 1'b1;
    #1;
    chk("arst_gpio", {24'h0, gpio_out}, 32'h0);
    chk("arst_irq", {31'h0, timer_irq}, 32'h0);
    @(posedge CLK);
    #1 RESET = 1'b0;
    d_rw = 1'b0;
    model_reset();
    look(10'h040);
    chk("rst_wr_drop", ddata_r, ram_m[16]);
`ifdef DMEM_MMIO_TIMER_EN
    look(10'h3E4);
    chk("cyc_after_rst", ddata_r, 32'h0);
`endif
    for (int i = 0; i < 20; i++) step(10'(i * 4 + 10'h3D0), 32'h0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
